tnn_feature_packer: RTL and testbench

- Upstream feeder for the 7-input, 2-bit-per-input approximate TNN neuron.
- Accepts raw 8-bit feature samples as a valid/ready stream and quantizes each to 2 bits against three runtime-programmable thresholds per feature.
- Packs the 7 quantized features into one 14-bit vector, buffers it and presents it to the neuron with a valid/ready handshake.

---
 rtl/tnn_pkg.sv | 23 ++
 rtl/tnn_quantizer.sv | 17 +
 rtl/tnn_feature_packer.sv | 154 +++++++++++++++
 tb/tb_tnn_feature_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared constants and types for the TNN feature packer and its quantizer.
package tnn_pkg;

    localparam int unsigned N_FEAT   = 7;
    localparam int unsigned IN_W     = 8;
    localparam int unsigned Q_W      = 2;
    localparam int unsigned N_THR    = 2**Q_W - 1;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned THR_RST0 = 64;
    localparam int unsigned THR_RST1 = 128;
    localparam int unsigned THR_RST2 = 192;

    typedef logic [Q_W-1:0]        q_feat_t;
    typedef logic [N_FEAT*Q_W-1:0] packed_vec_t;
    typedef logic [IN_W-1:0]       thr_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISCARD
    } pk_state_t;

endpackage

// File: rtl/tnn_quantizer.sv
// Combinational 2-bit quantizer: counts how many thresholds the sample reaches.
module tnn_quantizer
    import tnn_pkg::*;
(
    input  logic [IN_W-1:0] d,
    input  logic [IN_W-1:0] t0,
    input  logic [IN_W-1:0] t1,
    input  logic [IN_W-1:0] t2,
    output logic [Q_W-1:0]  q_c
);

    // Thresholds need not be ordered, so each compare contributes independently.
    always_comb begin
        q_c = Q_W'(d >= t0) + Q_W'(d >= t1) + Q_W'(d >= t2);
    end

endmodule

// File: rtl/tnn_feature_packer.sv
// Quantizes a 7-beat raw feature stream and packs it into one 14-bit vector
// for the TNN neuron, with a one-deep assembly buffer behind the output register.
module tnn_feature_packer
    import tnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  feat_valid,
    output logic                  feat_ready,
    input  logic [IN_W-1:0]       feat_data,
    input  logic                  feat_last,
    input  logic                  thr_we,
    input  logic [2:0]            thr_feat,
    input  logic [1:0]            thr_lvl,
    input  logic [IN_W-1:0]       thr_data,
    output logic                  vec_valid,
    input  logic                  vec_ready,
    output logic [N_FEAT*Q_W-1:0] vec_data,
    output logic                  err_frame,
    output logic                  err_thr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    thr_t        thr_q [N_FEAT][N_THR];
    pk_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    packed_vec_t asm_q, completed_c;
    logic        asm_full_q;

    logic        out_free_c;
    logic        beat_c;
    logic        slot_we_c;
    logic        complete_c;
    logic        frame_err_c;
    logic        thr_ok_c;
    q_feat_t     q_c;

    assign out_free_c = !vec_valid || vec_ready;
    assign feat_ready = !asm_full_q || out_free_c;
    assign beat_c     = feat_valid && feat_ready;
    assign thr_ok_c   = (thr_feat < 3'(N_FEAT)) && (thr_lvl < 2'(N_THR));

    tnn_quantizer u_quant (
        .d   (feat_data),
        .t0  (thr_q[idx_q][0]),
        .t1  (thr_q[idx_q][1]),
        .t2  (thr_q[idx_q][2]),
        .q_c (q_c)
    );

    // Assembly contents with the current beat's code dropped into its slot.
    always_comb begin
        completed_c = asm_q;
        completed_c[int'(idx_q) * Q_W +: Q_W] = q_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slot_we_c   = 1'b0;
        complete_c  = 1'b0;
        frame_err_c = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (beat_c) begin
                    slot_we_c = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d       = '0;
                        complete_c  = feat_last;
                        frame_err_c = !feat_last;
                        state_d     = feat_last ? IDLE : DISCARD;
                    end else if (feat_last) begin
                        idx_d       = '0;
                        frame_err_c = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = COLLECT;
                    end
                end
            end
            DISCARD: begin
                if (beat_c && feat_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Assembly/output buffering: a finished vector bypasses into the output
    // register when it is free, otherwise it parks in the assembly buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q      <= '0;
            asm_full_q <= 1'b0;
            vec_data   <= '0;
            vec_valid  <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            err_frame <= frame_err_c;
            if (slot_we_c) begin
                asm_q <= completed_c;
            end
            if (asm_full_q && out_free_c) begin
                vec_data   <= asm_q;
                vec_valid  <= 1'b1;
                asm_full_q <= complete_c;
            end else if (complete_c && out_free_c) begin
                vec_data  <= completed_c;
                vec_valid <= 1'b1;
            end else begin
                if (complete_c) begin
                    asm_full_q <= 1'b1;
                end
                if (vec_valid && vec_ready) begin
                    vec_valid <= 1'b0;
                end
            end
        end
    end

    // Threshold table; a same-cycle beat still sees the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_thr <= 1'b0;
            for (int f = 0; f < int'(N_FEAT); f++) begin
                thr_q[f][0] <= IN_W'(THR_RST0);
                thr_q[f][1] <= IN_W'(THR_RST1);
                thr_q[f][2] <= IN_W'(THR_RST2);
            end
        end else begin
            err_thr <= thr_we && !thr_ok_c;
            if (thr_we && thr_ok_c) begin
                thr_q[thr_feat][thr_lvl] <= thr_data;
            end
        end
    end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Scoreboard bench for tnn_feature_packer: a threshold model predicts each packed
// vector when its beats are driven; vectors are compared as they are consumed.
module tb_tnn_feature_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic        feat_ready;
    logic [7:0]  feat_data;
    logic        feat_last;
    logic        thr_we;
    logic [2:0]  thr_feat;
    logic [1:0]  thr_lvl;
    logic [7:0]  thr_data;
    logic        vec_valid;
    logic        vec_ready;
    logic [13:0] vec_data;
    logic        err_frame;
    logic        err_thr;

    tnn_feature_packer dut (
        .clk        (clk),
        .rst        (rst),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .thr_we     (thr_we),
        .thr_feat   (thr_feat),
        .thr_lvl    (thr_lvl),
        .thr_data   (thr_data),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_data   (vec_data),
        .err_frame  (err_frame),
        .err_thr    (err_thr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          frame_cnt = 0;
    int          thr_cnt   = 0;
    int          rx_cnt    = 0;
    int          mthr [7][3];
    logic [13:0] exp_vec;
    logic [13:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int model_q(input int f, input int d);
        return int'(d >= mthr[f][0]) + int'(d >= mthr[f][1]) + int'(d >= mthr[f][2]);
    endfunction

    task automatic reset_model();
        for (int f = 0; f < 7; f++) begin
            mthr[f][0] = 64;
            mthr[f][1] = 128;
            mthr[f][2] = 192;
        end
    endtask

    // Consumer side: sampled on the falling edge, handshake completes on the next rise.
    always @(negedge clk) begin
        if (err_frame) frame_cnt++;
        if (err_thr) thr_cnt++;
        if (!rst && vec_valid && vec_ready) begin
            rx_cnt++;
            if (sb.size() == 0) check("unexpected vector", 32'(vec_data), 32'hFFFF_FFFF);
            else check("vec_data", 32'(vec_data), 32'(sb.pop_front()));
        end
    end

    task automatic send_beat(input int d, input logic last);
        logic ok;
        int   tmo = 0;
        feat_valid = 1'b1;
        feat_data  = 8'(d);
        feat_last  = last;
        forever begin
            @(negedge clk);
            ok = feat_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            tmo++;
            if (tmo > 200) begin
                check("feat_ready timeout", 32'(feat_ready), 32'd1);
                break;
            end
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // Drives feature f of a well-framed sample and predicts its slot.
    task automatic beat(input int f, input int d);
        exp_vec[2*f +: 2] = 2'(model_q(f, d));
        send_beat(d, f == 6);
        if (f == 6) sb.push_back(exp_vec);
    endtask

    task automatic send_sample(input int d0, input int d1, input int d2, input int d3,
                               input int d4, input int d5, input int d6);
        beat(0, d0); beat(1, d1); beat(2, d2); beat(3, d3);
        beat(4, d4); beat(5, d5); beat(6, d6);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic thr_write(input int f, input int l, input int v);
        thr_we   = 1'b1;
        thr_feat = 3'(f);
        thr_lvl  = 2'(l);
        thr_data = 8'(v);
        @(posedge clk);
        #1;
        thr_we = 1'b0;
    endtask

    int          f0, t0;
    logic [13:0] held;

    initial begin
        rst = 1'b1; feat_valid = 1'b0; feat_data = '0; feat_last = 1'b0;
        thr_we = 1'b0; thr_feat = '0; thr_lvl = '0; thr_data = '0; vec_ready = 1'b1;
        exp_vec = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("reset vec_valid", 32'(vec_valid), 32'd0);
        check("reset vec_data", 32'(vec_data), 32'd0);
        check("reset feat_ready", 32'(feat_ready), 32'd1);
        check("reset err_frame", 32'(err_frame), 32'd0);
        rst = 1'b0;
        wait_cycles(1);

        // Basic quantization with reset thresholds and one-cycle output latency.
        send_sample(0, 64, 127, 128, 191, 192, 255);
        check("t1 vec_valid", 32'(vec_valid), 32'd1);
        check("t1 vec_data", 32'(vec_data), 32'(14'b11_11_10_10_01_01_00));
        drain();

        // Back-to-back samples with a stalled consumer.
        vec_ready = 1'b0;
        send_sample(10, 70, 130, 200, 5, 90, 250);
        send_sample(255, 0, 64, 63, 128, 127, 192);
        check("t2 feat_ready stalled", 32'(feat_ready), 32'd0);
        held = vec_data;
        wait_cycles(3);
        check("t2 feat_ready still stalled", 32'(feat_ready), 32'd0);
        check("t2 vec_valid held", 32'(vec_valid), 32'd1);
        check("t2 vec_data stable", 32'(vec_data), 32'(held));
        vec_ready = 1'b1;
        #1;
        check("t2 feat_ready on drain", 32'(feat_ready), 32'd1);
        drain();
        check("t2 rx count", 32'(rx_cnt), 32'd3);

        // Early feat_last: one framing error, nothing emitted.
        f0 = frame_cnt;
        send_beat(100, 1'b0); send_beat(100, 1'b0); send_beat(100, 1'b1);
        wait_cycles(3);
        check("t3 err_frame", 32'(frame_cnt - f0), 32'd1);
        check("t3 no vector", 32'(rx_cnt), 32'd3);
        send_sample(200, 150, 100, 50, 0, 255, 129);
        drain();

        // Missing feat_last: error, extras dropped until last.
        f0 = frame_cnt;
        for (int i = 0; i < 7; i++) send_beat(i * 30, 1'b0);
        send_beat(255, 1'b0);
        send_beat(255, 1'b1);
        wait_cycles(3);
        check("t4 err_frame", 32'(frame_cnt - f0), 32'd1);
        check("t4 no vector", 32'(rx_cnt), 32'd4);
        send_sample(1, 65, 129, 193, 64, 128, 192);
        drain();

        // Threshold write in the same cycle as the affected beat.
        beat(0, 110); beat(1, 110);
        thr_we = 1'b1; thr_feat = 3'd2; thr_lvl = 2'd1; thr_data = 8'd100;
        beat(2, 110);
        thr_we = 1'b0;
        mthr[2][1] = 100;
        beat(3, 110); beat(4, 110); beat(5, 110); beat(6, 110);
        drain();
        check("t5 old threshold slot", 32'(model_q(2, 110)), 32'd2);
        send_sample(110, 110, 110, 110, 110, 110, 110);
        drain();
        t0 = thr_cnt;
        thr_write(0, 3, 0);
        thr_write(7, 0, 0);
        wait_cycles(1);
        check("t5 err_thr", 32'(thr_cnt - t0), 32'd2);
        send_sample(64, 63, 100, 99, 192, 191, 128);
        drain();

        // Asynchronous reset with a pending vector and a partial sample.
        vec_ready = 1'b0;
        send_sample(255, 255, 255, 255, 255, 255, 255);
        send_beat(10, 1'b0); send_beat(10, 1'b0); send_beat(10, 1'b0); send_beat(10, 1'b0);
        check("t6 vec_valid before rst", 32'(vec_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6 vec_valid async drop", 32'(vec_valid), 32'd0);
        sb.delete();
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        vec_ready = 1'b1;
        check("t6 feat_ready after rst", 32'(feat_ready), 32'd1);
        send_sample(110, 127, 110, 191, 64, 192, 0);
        check("t6 vec_data", 32'(vec_data), 32'(14'b00_11_01_10_01_01_01));
        drain();

        // Randomized traffic with random backpressure.
        fork
            begin
                for (int s = 0; s < 6; s++) begin
                    send_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                                int'($urandom_range(0, 255)));
                end
            end
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1;
                    vec_ready = 1'($urandom_range(0, 1));
                end
                vec_ready = 1'b1;
            end
        join
        vec_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
